regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 8: register width in bits.
REQ-002 Parameter ADDR_W, default 2: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to read ports.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 raddr1, raddr2  input  ADDR_W each  read addresses, ports 1 and 2.
REQ-008 rdata1, rdata2  output  DATA_W each  combinational read data.
REQ-009 rvalid1, rvalid2  output  1 each  addressed register holds committed, non-pending data.
REQ-010 we0, we1  input  1 each  write enables, write ports 0 and 1.
REQ-011 waddr0, waddr1  input  ADDR_W each  write addresses.
REQ-012 wdata0, wdata1  input  DATA_W each  write data.
REQ-013 rsv_en  input  1  reserve request: mark a register pending (result in flight).
REQ-014 rsv_addr  input  ADDR_W  register to reserve.
REQ-015 pend_cnt  output  ADDR_W+1  count of registers currently pending.

Function
REQ-016 Storage: DEPTH x DATA_W registers plus one pending bit per register.
REQ-017 Write: on rising clk with weN=1, regs[waddrN] <= wdataN; visible on reads the following cycle (BYPASS=0) or same cycle (BYPASS=1).
REQ-018 Write collision: we0=we1=1 and waddr0==waddr1 -> port 1 data stored; port 0 write dropped.
REQ-019 Read: rdataK = regs[raddrK] with zero added read latency, no clock involvement.
REQ-020 Bypass (BYPASS=1): raddrK matching an enabled write address -> rdataK = that wdata; on double match, wdata1.
REQ-021 Pending set: rsv_en=1 sets pending[rsv_addr] at the clock edge.
REQ-022 Pending clear: any write to a register clears its pending bit at the clock edge.
REQ-023 Reserve and write to same register in one cycle: data written and pending bit left SET (new producer wins).
REQ-024 Reserve of an already-pending register: bit stays set; no error, no count change.
REQ-025 rvalidK = !pending[raddrK]; with BYPASS=1, also 1 when raddrK matches an enabled write address this cycle, unless rsv_en targets the same address.
REQ-026 pend_cnt = population count of pending bits, registered, updated the same edge as the bits, range 0..DEPTH.
REQ-027 ZERO_REG=1: rdataK=0 and rvalidK=1 when raddrK==0, bypass included; writes/reservations to address 0 have no effect; pending[0] is never set.
REQ-028 Out-of-range addresses cannot occur; all 2**ADDR_W addresses are valid.

Reset
REQ-029 reset=0 asynchronously clears all registers to 0, all pending bits to 0, pend_cnt to 0, independent of clk.
REQ-030 During reset, writes and reservations are ignored; rvalid1=rvalid2=1 and rdata1=rdata2=0.
REQ-031 Reset asserted mid-operation discards in-flight reservations; first post-release edge behaves as from power-up.

Verification
REQ-032 Reset, then we0=1 waddr0=2 wdata0=0xA5; next cycle raddr1=2 -> rdata1=0xA5, rvalid1=1.
REQ-033 we0=1 waddr0=1 wdata0=0x11, we1=1 waddr1=1 wdata1=0x22 same cycle -> regs[1]=0x22; BYPASS=1 same-cycle raddr1=1 -> rdata1=0x22.
REQ-034 rsv_en addr 3 -> rvalid(raddr=3)=0, pend_cnt=1; later we1 addr 3 data 0x7E -> rvalid=1, rdata=0x7E, pend_cnt=0.
REQ-035 rsv_en addr 2 and we0 addr 2 data 0x55 same cycle -> regs[2]=0x55, rvalid for 2 =0, pend_cnt=1.
REQ-036 ZERO_REG=1: we0 addr 0 data 0xFF, rsv_en addr 0 -> rdata for addr 0 =0, rvalid=1, pend_cnt=0.
REQ-037 Reserve all 4 registers (pend_cnt=4), assert reset=0 between clock edges -> immediately pend_cnt=0, all rdata=0, rvalid=1.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, two write ports,
// and a pending (reservation) bit per register with a registered pending count.
module regfile_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid1,
    output logic              rvalid2,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [ADDR_W:0]   pend_cnt_nxt;

    logic wen0;
    logic wen1;
    logic rsv;

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_valid;

    // Effective write/reserve strobes: port 0 loses a same-address collision,
    // and register 0 is immune to writes and reservations when hardwired.
    always_comb begin
        wen0 = we0 && !(we1 && (waddr1 == waddr0))
                   && !((ZERO_REG != 0) && (waddr0 == '0));
        wen1 = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
        rsv  = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    end

    // Next pending vector (writes clear, reservation set last so it wins)
    // and its population count.
    always_comb begin
        pending_nxt = pending;
        if (wen0) pending_nxt[waddr0] = 1'b0;
        if (wen1) pending_nxt[waddr1] = 1'b0;
        if (rsv)  pending_nxt[rsv_addr] = 1'b1;
        pend_cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_cnt_nxt = pend_cnt_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
        end
    end

    // Storage, pending bits and pending count with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wen0) regs[waddr0] <= wdata0;
            if (wen1) regs[waddr1] <= wdata1;
            pending  <= pending_nxt;
            pend_cnt <= pend_cnt_nxt;
        end
    end

    assign rd_addr = {raddr2, raddr1};

    // Read ports: stored data, optional forwarding of this cycle's writes
    // (port 1 has priority), zero-register and reset overrides last.
    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            rd_data[k]  = regs[rd_addr[k]];
            rd_valid[k] = !pending[rd_addr[k]];
            if (BYPASS != 0) begin
                if (we1 && (waddr1 == rd_addr[k])) begin
                    rd_data[k] = wdata1;
                end else if (we0 && (waddr0 == rd_addr[k])) begin
                    rd_data[k] = wdata0;
                end
                if ((we0 && (waddr0 == rd_addr[k]) || we1 && (waddr1 == rd_addr[k]))
                    && !(rsv_en && (rsv_addr == rd_addr[k]))) begin
                    rd_valid[k] = 1'b1;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
                rd_data[k]  = '0;
                rd_valid[k] = 1'b1;
            end
            if (!reset) begin
                rd_data[k]  = '0;
                rd_valid[k] = 1'b1;
            end
        end
    end

    assign rdata1  = rd_data[0];
    assign rdata2  = rd_data[1];
    assign rvalid1 = rd_valid[0];
    assign rvalid2 = rd_valid[1];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: a default (bypassing) instance and a zero-register,
// non-bypassing instance share stimulus and are compared to a reference model.
module tb_regfile_param;

    logic       clk;
    logic       reset;
    logic [1:0] raddr1, raddr2;
    logic       we0, we1;
    logic [1:0] waddr0, waddr1;
    logic [7:0] wdata0, wdata1;
    logic       rsv_en;
    logic [1:0] rsv_addr;

    logic [7:0] rdata1_a, rdata2_a, rdata1_z, rdata2_z;
    logic       rvalid1_a, rvalid2_a, rvalid1_z, rvalid2_z;
    logic [2:0] pend_cnt_a, pend_cnt_z;

    int n_checks;
    int n_errors;

    // model state, index 0: default instance, index 1: ZERO_REG=1, BYPASS=0
    logic [7:0] m_regs [2][4];
    bit         m_pend [2][4];

    regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a),
        .rvalid1(rvalid1_a), .rvalid2(rvalid2_a),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_cnt(pend_cnt_a)
    );

    regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut_z (
        .clk(clk), .reset(reset),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_z), .rdata2(rdata2_z),
        .rvalid1(rvalid1_z), .rvalid2(rvalid2_z),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_cnt(pend_cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                m_regs[c][r] = 8'h00;
                m_pend[c][r] = 1'b0;
            end
        end
    endtask

    // Clock-edge effect: writes in port order (later port overrides),
    // then the reservation marks its target.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (we0 && !(c == 1 && waddr0 == 2'd0)) begin
                m_regs[c][waddr0] = wdata0;
                m_pend[c][waddr0] = 1'b0;
            end
            if (we1 && !(c == 1 && waddr1 == 2'd0)) begin
                m_regs[c][waddr1] = wdata1;
                m_pend[c][waddr1] = 1'b0;
            end
            if (rsv_en && !(c == 1 && rsv_addr == 2'd0)) begin
                m_pend[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    function automatic int unsigned model_count(input int c);
        int unsigned n = 0;
        for (int r = 0; r < 4; r++) n += m_pend[c][r];
        return n;
    endfunction

    // Returns {valid, data} a read of address a should currently show.
    function automatic logic [8:0] exp_read(input int c, input logic [1:0] a);
        logic [7:0] d;
        logic       v;
        bit         fwd;
        if (!reset) return {1'b1, 8'h00};
        if (c == 1 && a == 2'd0) return {1'b1, 8'h00};
        d = m_regs[c][a];
        v = !m_pend[c][a];
        fwd = 1'b0;
        if (c == 0) begin
            if (we0 && waddr0 == a) begin d = wdata0; fwd = 1'b1; end
            if (we1 && waddr1 == a) begin d = wdata1; fwd = 1'b1; end
            if (fwd && !(rsv_en && rsv_addr == a)) v = 1'b1;
        end
        return {v, d};
    endfunction

    task automatic check_comb();
        logic [8:0] e1a, e2a, e1z, e2z;
        e1a = exp_read(0, raddr1);
        e2a = exp_read(0, raddr2);
        e1z = exp_read(1, raddr1);
        e2z = exp_read(1, raddr2);
        check_eq("a.rdata1",  rdata1_a,  e1a[7:0]);
        check_eq("a.rvalid1", rvalid1_a, e1a[8]);
        check_eq("a.rdata2",  rdata2_a,  e2a[7:0]);
        check_eq("a.rvalid2", rvalid2_a, e2a[8]);
        check_eq("z.rdata1",  rdata1_z,  e1z[7:0]);
        check_eq("z.rvalid1", rvalid1_z, e1z[8]);
        check_eq("z.rdata2",  rdata2_z,  e2z[7:0]);
        check_eq("z.rvalid2", rvalid2_z, e2z[8]);
    endtask

    task automatic check_cnt();
        check_eq("a.pend_cnt", pend_cnt_a, model_count(0));
        check_eq("z.pend_cnt", pend_cnt_z, model_count(1));
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; rsv_addr = 0;
    endtask

    // One clock: check reads with inputs settled, clock, then check count.
    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_cnt();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 0;
        raddr1 = 0; raddr2 = 1;
        idle();
        model_clear();
        #1;
        check_comb();
        check_cnt();
        @(posedge clk);
        #1;
        check_cnt();
        reset = 1;

        // write then read back next cycle
        we0 = 1; waddr0 = 2; wdata0 = 8'hA5;
        cycle();
        idle(); raddr1 = 2;
        #1;
        check_eq("r032.rdata1", rdata1_a, 8'hA5);
        check_eq("r032.rvalid1", rvalid1_a, 1);
        cycle();

        // write collision, port 1 wins, bypass shows it same cycle
        we0 = 1; waddr0 = 1; wdata0 = 8'h11;
        we1 = 1; waddr1 = 1; wdata1 = 8'h22; raddr1 = 1;
        #1;
        check_eq("r033.bypass", rdata1_a, 8'h22);
        check_eq("r033.nobypass", rdata1_z, 8'h00);
        cycle();
        idle();
        #1;
        check_eq("r033.stored_a", rdata1_a, 8'h22);
        check_eq("r033.stored_z", rdata1_z, 8'h22);
        cycle();

        // reserve then satisfy
        rsv_en = 1; rsv_addr = 3;
        cycle();
        idle(); raddr1 = 3;
        #1;
        check_eq("r034.rvalid_pend", rvalid1_a, 0);
        check_eq("r034.cnt_pend", pend_cnt_a, 1);
        cycle();
        we1 = 1; waddr1 = 3; wdata1 = 8'h7E;
        cycle();
        idle();
        #1;
        check_eq("r034.rvalid_done", rvalid1_a, 1);
        check_eq("r034.rdata_done", rdata1_a, 8'h7E);
        check_eq("r034.cnt_done", pend_cnt_a, 0);
        cycle();

        // reserve and write the same register together
        rsv_en = 1; rsv_addr = 2; we0 = 1; waddr0 = 2; wdata0 = 8'h55;
        cycle();
        idle(); raddr1 = 2;
        #1;
        check_eq("r035.rdata", rdata1_a, 8'h55);
        check_eq("r035.rvalid", rvalid1_a, 0);
        check_eq("r035.cnt", pend_cnt_a, 1);
        we1 = 1; waddr1 = 2; wdata1 = 8'h33;
        cycle();

        // zero register ignores write and reservation
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 8'hFF; rsv_en = 1; rsv_addr = 0; raddr1 = 0;
        #1;
        check_eq("r036.rdata_same", rdata1_z, 8'h00);
        check_eq("r036.rvalid_same", rvalid1_z, 1);
        cycle();
        idle(); raddr1 = 0;
        #1;
        check_eq("r036.rdata", rdata1_z, 8'h00);
        check_eq("r036.rvalid", rvalid1_z, 1);
        check_eq("r036.cnt", pend_cnt_z, 0);
        cycle();

        // reserve everything, then reset between edges
        for (int r = 0; r < 4; r++) begin
            idle(); rsv_en = 1; rsv_addr = 2'(r);
            cycle();
        end
        idle();
        #1;
        check_eq("r037.cnt_full", pend_cnt_a, 4);
        #2;
        reset = 0;
        model_clear();
        #1;
        check_eq("r037.cnt_reset", pend_cnt_a, 0);
        for (int r = 0; r < 4; r++) begin
            raddr1 = 2'(r); raddr2 = 2'(3 - r);
            #1;
            check_comb();
        end
        we0 = 1; waddr0 = 1; wdata0 = 8'hC3; rsv_en = 1; rsv_addr = 1; raddr1 = 1;
        cycle();
        check_cnt();
        idle();
        reset = 1;

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            raddr1 = 2'($urandom_range(0, 3));
            raddr2 = 2'($urandom_range(0, 3));
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = 2'($urandom_range(0, 3));
            waddr1 = 2'($urandom_range(0, 3));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 0;
                model_clear();
                #1;
                check_comb();
                check_cnt();
                @(posedge clk);
                #1;
                check_cnt();
                check_comb();
                reset = 1;
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
